// File: rtl/vga_vram_scanner_if.sv
// Scanner-side bus: VRAM read port plus VGA pin outputs.
interface vga_vram_scanner_if #(
   parameter int unsigned COLOR_W = 3,
   parameter int unsigned ADDR_W  = 13
);
   logic [COLOR_W-1:0] iVramData;
   logic [ADDR_W-1:0]  oVramAddr;
   logic [COLOR_W-1:0] oRGB;
   logic               oHSync;
   logic               oVSync;
   logic               oFrameStart;

   modport master (
      input  iVramData,
      output oVramAddr, oRGB, oHSync, oVSync, oFrameStart
   );

   modport slave (
      output iVramData,
      input  oVramAddr, oRGB, oHSync, oVSync, oFrameStart
   );
endinterface

// File: rtl/vga_vram_scanner.sv
// VGA 640x480@60 scan-out of an 80x60 VRAM, each cell drawn as an 8x8 block.
// Define SCANNER_TESTPAT_EN to replace VRAM colors with 8-pixel vertical color bars.
module vga_vram_scanner #(
   parameter int unsigned COLOR_W   = 3,
   parameter int unsigned VRAM_COLS = 80,
   parameter int unsigned VRAM_ROWS = 60,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned H_VIS     = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VIS     = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33
) (
   input  logic               Clock,
   input  logic               Reset,
   vga_vram_scanner_if.master bus
);
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG = H_VIS + H_FP;
   localparam int unsigned HS_END = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG = V_VIS + V_FP;
   localparam int unsigned VS_END = VS_BEG + V_SYNC;

   logic               pe;
   logic [CNT_W-1:0]   hcnt;
   logic [CNT_W-1:0]   vcnt;
   logic [ADDR_W-1:0]  rowbase;
   logic               vis1;
   logic               hs1;
   logic               vs1;
   logic [ADDR_W-1:0]  vram_addr;
   logic [COLOR_W-1:0] rgb;
   logic               hsync;
   logic               vsync;
`ifdef SCANNER_TESTPAT_EN
   logic [CNT_W-1:0]   hcnt1;
`endif

   logic               h_wrap_c;
   logic               v_wrap_c;
   logic               row_step_c;
   logic [ADDR_W-1:0]  col_c;

   assign h_wrap_c = (hcnt == CNT_W'(H_TOT - 1));
   assign v_wrap_c = (vcnt == CNT_W'(V_TOT - 1));
   // Stepping stops at the last VRAM row so blanking lines keep addresses in range.
   assign row_step_c = (vcnt[2:0] == 3'd7) && (vcnt < CNT_W'(V_VIS - 1));
   assign col_c = (hcnt < CNT_W'(H_VIS)) ? ADDR_W'(hcnt >> 3) : ADDR_W'(VRAM_COLS - 1);

   // Counters, address stage and output stage, all advancing on pixel enable.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         pe        <= 1'b0;
         hcnt      <= '0;
         vcnt      <= '0;
         rowbase   <= '0;
         vis1      <= 1'b0;
         hs1       <= 1'b1;
         vs1       <= 1'b1;
         vram_addr <= '0;
         rgb       <= '0;
         hsync     <= 1'b1;
         vsync     <= 1'b1;
`ifdef SCANNER_TESTPAT_EN
         hcnt1     <= '0;
`endif
      end else begin
         pe <= ~pe;
         if (pe) begin
            hcnt <= h_wrap_c ? '0 : hcnt + CNT_W'(1);
            if (h_wrap_c) begin
               vcnt <= v_wrap_c ? '0 : vcnt + CNT_W'(1);
               if (v_wrap_c)
                  rowbase <= '0;
               else if (row_step_c)
                  rowbase <= rowbase + ADDR_W'(VRAM_COLS);
            end

            vram_addr <= rowbase + col_c;
            vis1      <= (hcnt < CNT_W'(H_VIS)) && (vcnt < CNT_W'(V_VIS));
            hs1       <= !((hcnt >= CNT_W'(HS_BEG)) && (hcnt < CNT_W'(HS_END)));
            vs1       <= !((vcnt >= CNT_W'(VS_BEG)) && (vcnt < CNT_W'(VS_END)));

`ifdef SCANNER_TESTPAT_EN
            hcnt1 <= hcnt;
            rgb   <= vis1 ? COLOR_W'(hcnt1 >> 3) : '0;
`else
            rgb   <= vis1 ? bus.iVramData : '0;
`endif
            hsync <= hs1;
            vsync <= vs1;
         end
      end
   end

   assign bus.oVramAddr   = vram_addr;
   assign bus.oRGB        = rgb;
   assign bus.oHSync      = hsync;
   assign bus.oVSync      = vsync;
   assign bus.oFrameStart = pe && (hcnt == '0) && (vcnt == '0);
endmodule

// File: tb/tb_vga_vram_scanner.sv
// Directed bench: full-size scanner for early-frame behaviour, a shrunken-timing
// instance for whole-frame behaviour; both checked every Clock against a position model.
module tb_vga_vram_scanner;
   localparam int HV[2]   = '{640, 32};
   localparam int HT[2]   = '{800, 48};
   localparam int HSA[2]  = '{656, 36};
   localparam int HSE[2]  = '{752, 44};
   localparam int VV[2]   = '{480, 24};
   localparam int VT[2]   = '{525, 30};
   localparam int VSA[2]  = '{490, 26};
   localparam int VSE[2]  = '{492, 28};
   localparam int COLS[2] = '{80, 4};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force7 = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   int mpe    = 0;
   int npe    = 0;
   int mh[2]  = '{0, 0};
   int mv[2]  = '{0, 0};

   vga_vram_scanner_if #(.COLOR_W(3), .ADDR_W(13)) bus_d ();
   vga_vram_scanner_if #(.COLOR_W(3), .ADDR_W(13)) bus_s ();

   vga_vram_scanner dut_d (.Clock(clk), .Reset(rst), .bus(bus_d));

   vga_vram_scanner #(
      .COLOR_W(3), .VRAM_COLS(4), .VRAM_ROWS(3), .ADDR_W(13),
      .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_s (.Clock(clk), .Reset(rst), .bus(bus_s));

   always #5 clk = ~clk;

   // VRAM models: synchronous read returning address LSBs.
   always_ff @(posedge clk) begin
      bus_d.iVramData <= force7 ? 3'd7 : bus_d.oVramAddr[2:0];
      bus_s.iVramData <= bus_s.oVramAddr[2:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int exp_addr(input int k, input int h, input int v);
      int col, rb;
      col = (h < HV[k]) ? h / 8 : COLS[k] - 1;
      rb  = (v < VV[k]) ? (v / 8) * COLS[k] : (VV[k] / 8 - 1) * COLS[k];
      return rb + col;
   endfunction

   task automatic back(input int k, input int n, output int h, output int v);
      h = mh[k] - n;
      v = mv[k];
      if (h < 0) begin
         h += HT[k];
         v -= 1;
         if (v < 0) v += VT[k];
      end
   endtask

   task automatic check_all();
      int h, v, ea, er, ehs, evs, efs;
      logic [31:0] oa, orgb, ohs, ovs, ofs;
      for (int k = 0; k < 2; k++) begin
         ea = 0; er = 0; ehs = 1; evs = 1;
         if (npe >= 1) begin
            back(k, 1, h, v);
            ea = exp_addr(k, h, v);
         end
         if (npe >= 2) begin
            back(k, 2, h, v);
`ifdef SCANNER_TESTPAT_EN
            er = (h < HV[k] && v < VV[k]) ? (h / 8) % 8 : 0;
`else
            er = (h < HV[k] && v < VV[k]) ? exp_addr(k, h, v) % 8 : 0;
`endif
            ehs = (h >= HSA[k] && h < HSE[k]) ? 0 : 1;
            evs = (v >= VSA[k] && v < VSE[k]) ? 0 : 1;
         end
         efs = (mpe == 1 && mh[k] == 0 && mv[k] == 0) ? 1 : 0;
         if (k == 0) begin
            oa = 32'(bus_d.oVramAddr); orgb = 32'(bus_d.oRGB);
            ohs = 32'(bus_d.oHSync); ovs = 32'(bus_d.oVSync); ofs = 32'(bus_d.oFrameStart);
         end else begin
            oa = 32'(bus_s.oVramAddr); orgb = 32'(bus_s.oRGB);
            ohs = 32'(bus_s.oHSync); ovs = 32'(bus_s.oVSync); ofs = 32'(bus_s.oFrameStart);
         end
         chk($sformatf("addr%0d", k), oa, 32'(ea));
         chk($sformatf("rgb%0d", k), orgb, 32'(er));
         chk($sformatf("hsync%0d", k), ohs, 32'(ehs));
         chk($sformatf("vsync%0d", k), ovs, 32'(evs));
         chk($sformatf("fstart%0d", k), ofs, 32'(efs));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         mpe = 0; npe = 0; mh = '{0, 0}; mv = '{0, 0};
      end else begin
         if (mpe == 1) begin
            npe++;
            for (int k = 0; k < 2; k++) begin
               if (mh[k] == HT[k] - 1) begin
                  mh[k] = 0;
                  mv[k] = (mv[k] == VT[k] - 1) ? 0 : mv[k] + 1;
               end else begin
                  mh[k] = mh[k] + 1;
               end
            end
         end
         mpe = 1 - mpe;
      end
      #1;
      check_all();
   endtask

   // Advance until instance k's counters have just stepped to (h, v).
   task automatic run_to(input int k, input int h, input int v);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(mpe == 0 && npe > 0 && mh[k] == h && mv[k] == v) && n < 40000);
      chk($sformatf("reach%0d_%0d_%0d", k, h, v), 32'(mh[k] * 1000 + mv[k]), 32'(h * 1000 + v));
   endtask

   initial begin
      int n, lows, amax;

      repeat (3) tick();
      chk("rst_addr_d", 32'(bus_d.oVramAddr), 0);
      chk("rst_rgb_d", 32'(bus_d.oRGB), 0);
      chk("rst_hs_d", 32'(bus_d.oHSync), 1);
      chk("rst_vs_d", 32'(bus_d.oVSync), 1);
      chk("rst_fs_d", 32'(bus_d.oFrameStart), 0);
      chk("rst_addr_s", 32'(bus_s.oVramAddr), 0);
      chk("rst_hs_s", 32'(bus_s.oHSync), 1);

      rst = 1'b0;
      tick();
      chk("fs_first_d", 32'(bus_d.oFrameStart), 1);
      chk("fs_first_s", 32'(bus_s.oFrameStart), 1);

      run_to(0, 9, 0);
      chk("addr_x8_y0", 32'(bus_d.oVramAddr), 1);
      run_to(0, 10, 0);
      chk("rgb_x8_y0", 32'(bus_d.oRGB), 1);
      run_to(0, 18, 0);
      chk("rgb_x16_y0", 32'(bus_d.oRGB), 2);
      run_to(0, 58, 0);
      chk("rgb_x56_y0", 32'(bus_d.oRGB), 7);

      run_to(0, 645, 0);
      force7 = 1'b1;
      run_to(0, 700, 0);
      chk("rgb_blank_d", 32'(bus_d.oRGB), 0);
      chk("addr_blank_d", 32'(bus_d.oVramAddr), 79);
      run_to(0, 790, 0);
      force7 = 1'b0;

      run_to(0, 1, 1);
      lows = 0;
      repeat (1600) begin
         tick();
         if (bus_d.oHSync === 1'b0) lows++;
      end
      chk("hsync_low_clocks", 32'(lows), 192);

      run_to(0, 1, 7);
      chk("addr_row7", 32'(bus_d.oVramAddr), 0);
      run_to(0, 1, 8);
      chk("addr_row8", 32'(bus_d.oVramAddr), 80);

      run_to(1, 0, 0);
      tick();
      n = 0; lows = 0; amax = 0;
      do begin
         tick();
         n++;
         if (bus_s.oVSync === 1'b0) lows++;
         if (int'(bus_s.oVramAddr) > amax) amax = int'(bus_s.oVramAddr);
      end while (bus_s.oFrameStart !== 1'b1 && n < 4000);
      chk("frame_period_s", 32'(n), 2880);
      chk("vsync_low_clocks_s", 32'(lows), 192);
      chk("addr_max_s", 32'(amax), 11);

      run_to(1, 1, 8);
      chk("addr_s_row8", 32'(bus_s.oVramAddr), 4);
      run_to(1, 1, 23);
      chk("addr_s_row23", 32'(bus_s.oVramAddr), 8);
      run_to(1, 1, 25);
      chk("addr_s_row25", 32'(bus_s.oVramAddr), 8);
      run_to(1, 1, 0);
      chk("addr_s_wrap", 32'(bus_s.oVramAddr), 0);

      run_to(1, 20, 10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_addr_s", 32'(bus_s.oVramAddr), 0);
      chk("mid_rst_rgb_s", 32'(bus_s.oRGB), 0);
      chk("mid_rst_hs_s", 32'(bus_s.oHSync), 1);
      chk("mid_rst_vs_s", 32'(bus_s.oVSync), 1);
      chk("mid_rst_fs_s", 32'(bus_s.oFrameStart), 0);
      chk("mid_rst_addr_d", 32'(bus_d.oVramAddr), 0);
      tick();
      chk("mid_rst_fs_first_s", 32'(bus_s.oFrameStart), 1);
      chk("mid_rst_fs_first_d", 32'(bus_d.oFrameStart), 1);
      repeat (3000) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
